// File: rtl/simon_seq_engine_if.sv
// Simon Says engine bus: game control inputs and display/status outputs.
// The board side (master) drives start/seed/btn; the engine (slave) drives the rest.
interface simon_seq_engine_if #(
    parameter int N_COLOURS = 4,
    parameter int MAX_LEN   = 16,
    parameter int LFSR_W    = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic                 start;
    logic [LFSR_W-1:0]    seed;
    logic [N_COLOURS-1:0] btn;
    logic [N_COLOURS-1:0] led;
    logic [LW-1:0]        level;
    logic [2:0]           state;
    logic                 win;
    logic                 lose;

    modport master (
        output start, seed, btn,
        input  led, level, state, win, lose
    );

    modport slave (
        input  start, seed, btn,
        output led, level, state, win, lose
    );
endinterface

// File: rtl/simon_seq_engine.sv
// Simon Says sequence engine: LFSR colour generation, playback on LEDs,
// and checking of player presses with an optional per-press timeout.
module simon_seq_engine #(
    parameter int               N_COLOURS      = 4,
    parameter int               MAX_LEN        = 16,
    parameter int               LFSR_W         = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS     = 8'hB8,
    parameter int               SHOW_CYCLES    = 8,
    parameter int               GAP_CYCLES     = 4,
    parameter int               TIMEOUT_CYCLES = 0
) (
    input logic               clk,
    input logic               rst_n,
    simon_seq_engine_if.slave bus
);
    localparam int CW   = $clog2(N_COLOURS);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int T1   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX = (T1 > TIMEOUT_CYCLES) ? T1 : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_INPUT    = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        seq_q [MAX_LEN];
    logic [CW-1:0]        seq_d [MAX_LEN];
    logic [N_COLOURS-1:0] btn_prev_q, btn_prev_d;

    logic [N_COLOURS-1:0] exp_led;
    logic                 press;
    logic                 is_last;

    function automatic logic [N_COLOURS-1:0] onehot(input logic [CW-1:0] c);
        logic [N_COLOURS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    assign exp_led = onehot(seq_q[idx_q[AW-1:0]]);
    assign press   = (bus.btn != '0) && (btn_prev_q == '0);
    assign is_last = (idx_q == len_q - LW'(1));

    // Next-state logic: game flow, sequence growth, playback and press checking.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        seq_d      = seq_q;
        btn_prev_d = bus.btn;

        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (bus.start) begin
                    lfsr_d  = (bus.seed == '0) ? '1 : bus.seed;
                    len_d   = '0;
                    state_d = S_APPEND;
                end
            end
            S_APPEND: begin
                seq_d[len_q[AW-1:0]] = lfsr_q[CW-1:0];
                len_d   = len_q + LW'(1);
                lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
                idx_d   = '0;
                timer_d = '0;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (timer_q == TW'(SHOW_CYCLES - 1)) begin
                    timer_d = '0;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SHOW_OFF: begin
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    timer_d = '0;
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        idx_d   = idx_q + LW'(1);
                        state_d = S_SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_INPUT: begin
                if (press) begin
                    timer_d = '0;
                    if (bus.btn == exp_led) begin
                        if (is_last) begin
                            state_d = (len_q == LW'(MAX_LEN)) ? S_WIN : S_APPEND;
                        end else begin
                            idx_d = idx_q + LW'(1);
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_LOSE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '1;
            len_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            seq_q      <= '{default: '0};
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            seq_q      <= seq_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign bus.led   = (state_q == S_SHOW_ON) ? exp_led : '0;
    assign bus.level = len_q;
    assign bus.state = state_q;
    assign bus.win   = (state_q == S_WIN);
    assign bus.lose  = (state_q == S_LOSE);
endmodule
